// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the FSM state encoding, the default widths (D, L, CW) and the
// saturating-increment helper used by the statistics counters.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int DEF_D  = 6;
  localparam int DEF_L  = 3;
  localparam int DEF_CW = 16;

  // Increment that sticks at max instead of wrapping. Callers pass values
  // zero-extended to 32 bits and truncate the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between the PC sequencer and its surroundings.
// slave : the sequencer (consumes decode/PC inputs, drives PC control + stats).
// master: the core side (drives decode/PC inputs, observes PC control + stats).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int L  = DEF_L,
  parameter int CW = DEF_CW
);
  logic          start;
  logic [D-1:0]  prog_ctr;
  logic          stall;
  logic          halt_req;
  logic          branch_req;
  logic          branch_cond;
  logic [L-1:0]  lut_idx;
  logic          lut_wr_en;
  logic [L-1:0]  lut_wr_idx;
  logic [D-1:0]  lut_wr_data;
  logic          jump_en;
  logic [D-1:0]  target;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] taken_cnt;

  modport master (
    output start, prog_ctr, stall, halt_req, branch_req, branch_cond, lut_idx,
           lut_wr_en, lut_wr_idx, lut_wr_data,
    input  jump_en, target, running, done, cycle_cnt, taken_cnt
  );

  modport slave (
    input  start, prog_ctr, stall, halt_req, branch_req, branch_cond, lut_idx,
           lut_wr_en, lut_wr_idx, lut_wr_data,
    output jump_en, target, running, done, cycle_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_lut.sv
// Branch-target register file: 2^L entries of D bits, cleared by reset.
// Latency: write lands at the clock edge; read is combinational, so a read
// of the entry being written this cycle still returns the old contents.
// Ports: clk, reset (async active-low), wr_en_i/wr_idx_i/wr_data_i, rd_idx_i -> rd_data_o.
module branch_lut #(
  parameter int D = 6,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [L-1:0] wr_idx_i,
  input  logic [D-1:0] wr_data_i,
  input  logic [L-1:0] rd_idx_i,
  output logic [D-1:0] rd_data_o
);

  localparam int N = 1 << L;

  logic [D-1:0] mem_q [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses increment / LUT redirect / hold for the
// PC each cycle, runs the IDLE->RUN->HALTED lifecycle and keeps saturating
// run statistics. Latency: jump_en/target/running/done are combinational
// (Mealy); the PC applies them at the next edge, giving zero-bubble branches.
// Ports: clk, reset (async active-low), bus (pc_sequencer_if.slave).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int L  = DEF_L,
  parameter int CW = DEF_CW
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [31:0] CNT_MAX = 32'({CW{1'b1}});

  seq_state_t    state_q;
  logic [CW-1:0] cycle_q;
  logic [CW-1:0] taken_q;
  logic [CW-1:0] cycle_d;
  logic [CW-1:0] taken_d;
  logic [D-1:0]  lut_rd_data;
  logic          branch_taken;
  logic          jump_en_d;
  logic [D-1:0]  target_d;

  branch_lut #(.D(D), .L(L)) u_lut (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.lut_wr_en),
    .wr_idx_i  (bus.lut_wr_idx),
    .wr_data_i (bus.lut_wr_data),
    .rd_idx_i  (bus.lut_idx),
    .rd_data_o (lut_rd_data)
  );

  assign branch_taken = bus.branch_req && bus.branch_cond;
  assign cycle_d      = CW'(sat_inc(32'(cycle_q), CNT_MAX));
  assign taken_d      = CW'(sat_inc(32'(taken_q), CNT_MAX));

  // Next-PC mux. A hold is expressed as a jump to the live prog_ctr, so the
  // PC never needs a separate enable.
  always_comb begin
    jump_en_d = 1'b1;
    target_d  = '0;
    unique case (state_q)
      IDLE: begin
        jump_en_d = 1'b1;
        target_d  = '0;
      end
      RUN: begin
        if (bus.stall || bus.halt_req) begin
          jump_en_d = 1'b1;
          target_d  = bus.prog_ctr;
        end else if (branch_taken) begin
          jump_en_d = 1'b1;
          target_d  = lut_rd_data;
        end else begin
          jump_en_d = 1'b0;
          target_d  = bus.prog_ctr;
        end
      end
      HALTED: begin
        jump_en_d = 1'b1;
        target_d  = bus.prog_ctr;
      end
      default: begin
        jump_en_d = 1'b1;
        target_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cycle_q <= '0;
      taken_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            cycle_q <= '0;
            taken_q <= '0;
          end
        end
        RUN: begin
          // A stalled cycle does nothing at all: no count, no halt, no branch.
          if (!bus.stall) begin
            cycle_q <= cycle_d;
            if (bus.halt_req) begin
              state_q <= HALTED;
            end else if (branch_taken) begin
              taken_q <= taken_d;
            end
          end
        end
        HALTED: begin
          if (bus.start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.jump_en   = jump_en_d;
  assign bus.target    = target_d;
  assign bus.running   = (state_q == RUN);
  assign bus.done      = (state_q == HALTED);
  assign bus.cycle_cnt = cycle_q;
  assign bus.taken_cnt = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the
// loop. Expected values are queued as each step is driven and compared
// against the DUT after the step's edge (or immediately for Mealy outputs).
module tb_pc_sequencer;

  localparam int D  = 6;
  localparam int L  = 3;
  localparam int CW = 4;

  localparam int S_PC = 0, S_JE = 1, S_TG = 2, S_RN = 3, S_DN = 4, S_CC = 5, S_TK = 6;

  logic clk = 1'b0;
  logic reset;
  logic [D-1:0] pc = 6'h15;

  pc_sequencer_if #(.D(D), .L(L), .CW(CW)) bus ();

  pc_sequencer #(.D(D), .L(L), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The PC itself: load target on jump_en, otherwise increment (wraps naturally).
  always @(posedge clk) pc <= bus.jump_en ? bus.target : pc + 6'd1;
  assign bus.prog_ctr = pc;

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_PC:    return 32'(pc);
      S_JE:    return 32'(bus.jump_en);
      S_TG:    return 32'(bus.target);
      S_RN:    return 32'(bus.running);
      S_DN:    return 32'(bus.done);
      S_CC:    return 32'(bus.cycle_cnt);
      S_TK:    return 32'(bus.taken_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
  endtask

  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_drain();
    tick();
    drain();
  endtask

  task automatic lut_wr(input logic en, input logic [L-1:0] idx, input logic [D-1:0] dat);
    bus.lut_wr_en   = en;
    bus.lut_wr_idx  = idx;
    bus.lut_wr_data = dat;
  endtask

  task automatic br(input logic req, input logic cond, input logic [L-1:0] idx);
    bus.branch_req  = req;
    bus.branch_cond = cond;
    bus.lut_idx     = idx;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.halt_req = 1'b0;
    br(1'b0, 1'b0, '0);
    lut_wr(1'b0, '0, '0);

    // Reset state
    #1;
    ex("rst_jump", S_JE, 1); ex("rst_tgt", S_TG, 0); ex("rst_run", S_RN, 0);
    ex("rst_done", S_DN, 0); ex("rst_cyc", S_CC, 0); ex("rst_tkn", S_TK, 0);
    drain();
    ex("rst_pc", S_PC, 0);
    tick_drain();

    // Start; load lut[5]=0x2A while still IDLE
    reset     = 1'b1;
    bus.start = 1'b1;
    lut_wr(1'b1, 3'd5, 6'h2A);
    ex("start_pc", S_PC, 0); ex("start_run", S_RN, 1); ex("start_cyc", S_CC, 0);
    tick_drain();
    bus.start = 1'b0;
    lut_wr(1'b0, '0, '0);
    #1;
    ex("run_jump", S_JE, 0);
    drain();
    for (int i = 1; i <= 4; i++) begin
      ex("count_pc", S_PC, 32'(i));
      tick_drain();
    end
    ex("count_cyc", S_CC, 4);
    drain();

    // Taken branch at PC=4 via lut[5]; also load lut[1]=4 to come back
    br(1'b1, 1'b1, 3'd5);
    lut_wr(1'b1, 3'd1, 6'd4);
    #1;
    ex("br_jump", S_JE, 1); ex("br_tgt", S_TG, 32'h2A);
    drain();
    ex("br_pc", S_PC, 32'h2A); ex("br_tkn", S_TK, 1);
    tick_drain();
    lut_wr(1'b0, '0, '0);
    br(1'b1, 1'b1, 3'd1);
    ex("back_pc", S_PC, 4); ex("back_tkn", S_TK, 2);
    tick_drain();

    // Not-taken branch at PC=4
    br(1'b1, 1'b0, 3'd5);
    #1;
    ex("nt_jump", S_JE, 0);
    drain();
    ex("nt_pc", S_PC, 5); ex("nt_tkn", S_TK, 2); ex("nt_cyc", S_CC, 7);
    tick_drain();
    br(1'b0, 1'b0, '0);
    ex("seq_pc", S_PC, 6);
    tick_drain();
    ex("seq_pc", S_PC, 7); ex("seq_cyc", S_CC, 9);
    tick_drain();

    // Stall beats halt and taken branch for 3 cycles
    bus.stall    = 1'b1;
    bus.halt_req = 1'b1;
    br(1'b1, 1'b1, 3'd5);
    #1;
    ex("stall_jump", S_JE, 1); ex("stall_tgt", S_TG, 7);
    drain();
    for (int i = 0; i < 3; i++) begin
      ex("stall_pc", S_PC, 7); ex("stall_run", S_RN, 1);
      ex("stall_cyc", S_CC, 9); ex("stall_tkn", S_TK, 2);
      tick_drain();
    end

    // Release stall: halt wins over the branch
    bus.stall = 1'b0;
    ex("halt_pc", S_PC, 7); ex("halt_done", S_DN, 1); ex("halt_run", S_RN, 0);
    ex("halt_cyc", S_CC, 10); ex("halt_tkn", S_TK, 2);
    tick_drain();
    bus.halt_req = 1'b0;
    br(1'b0, 1'b0, '0);
    ex("hold_pc", S_PC, 7); ex("hold_done", S_DN, 1);
    tick_drain();

    // Restart: HALTED -> IDLE -> PC 0 -> RUN with counters cleared
    bus.start = 1'b1;
    ex("rs_pc", S_PC, 7); ex("rs_done", S_DN, 0); ex("rs_run", S_RN, 0);
    tick_drain();
    bus.start = 1'b0;
    #1;
    ex("idle_jump", S_JE, 1); ex("idle_tgt", S_TG, 0);
    drain();
    ex("idle_pc", S_PC, 0); ex("idle_cyc_kept", S_CC, 10);
    tick_drain();
    bus.start = 1'b1;
    lut_wr(1'b1, 3'd2, 6'h10);
    ex("rs_run2", S_RN, 1); ex("rs_cyc_clr", S_CC, 0); ex("rs_tkn_clr", S_TK, 0);
    tick_drain();
    bus.start = 1'b0;

    // LUT read/write collision on index 2
    lut_wr(1'b1, 3'd2, 6'h20);
    br(1'b1, 1'b1, 3'd2);
    ex("coll_old", S_PC, 32'h10); ex("coll_tkn", S_TK, 1);
    tick_drain();
    lut_wr(1'b1, 3'd3, 6'h3F);
    ex("coll_new", S_PC, 32'h20); ex("coll_tkn2", S_TK, 2);
    tick_drain();
    lut_wr(1'b0, '0, '0);

    // PC wrap 0x3F -> 0x00
    br(1'b1, 1'b1, 3'd3);
    ex("to_3f", S_PC, 32'h3F); ex("tkn3", S_TK, 3); ex("cyc3", S_CC, 3);
    tick_drain();
    br(1'b0, 1'b0, '0);
    ex("wrap_pc", S_PC, 0); ex("wrap_cyc", S_CC, 4);
    tick_drain();

    // Asynchronous reset mid-run, between edges
    reset = 1'b0;
    #1;
    ex("ar_jump", S_JE, 1); ex("ar_tgt", S_TG, 0); ex("ar_run", S_RN, 0);
    ex("ar_done", S_DN, 0); ex("ar_tkn", S_TK, 0); ex("ar_cyc", S_CC, 0);
    drain();
    tick();
    reset     = 1'b1;
    bus.start = 1'b1;
    ex("ar_restart", S_RN, 1);
    tick_drain();
    bus.start = 1'b0;

    // Every LUT entry must have been cleared
    for (int i = 0; i < (1 << L); i++) begin
      br(1'b1, 1'b1, L'(i));
      #1;
      ex("lut_clr_tgt", S_TG, 0); ex("lut_clr_jump", S_JE, 1);
      drain();
      tick();
    end
    br(1'b0, 1'b0, '0);
    ex("lut_clr_pc", S_PC, 0); ex("loop_tkn", S_TK, 8);
    drain();

    // Saturation of the cycle counter (8 + 10 > 15)
    repeat (10) tick();
    ex("sat_cyc", S_CC, 15); ex("sat_tkn", S_TK, 8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
